// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for a UART receiver.
// Each completed frame is stored with an error tag in a first-word-fall-through
// FIFO and offered on a valid/ready stream. Parity and stop-bit errors are
// counted in saturating counters, and a sticky flag records frames lost to a
// full FIFO.
//
// Build option: RX_CTRL_DROP_PARITY_EN
//   undefined (default) - parity-error frames are queued with err_tag=1
//   defined             - parity-error frames are discarded; m_err is tied to 0
module uart_rx_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_parity_err,
    input  logic                     rx_stop_err,
    output logic                     m_valid,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_err,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic [CNT_W-1:0]         parity_err_cnt,
    output logic [CNT_W-1:0]         stop_err_cnt,
    input  logic                     clr_stats
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + 1;

    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] ONE_OCC  = OCC_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Storage and state
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0] stop_cnt_q, stop_cnt_d;

    // Handshake terms
    logic             push_req;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             push_drop;
    logic             wr_tag;
    logic [ENT_W-1:0] head;

    // Push qualification: a stop-error frame never enters the FIFO, and in
    // drop mode neither does a frame with a parity mismatch.
    always_comb begin
        full = (count_q == FULL_OCC);
        pop  = m_valid && m_ready;
`ifdef RX_CTRL_DROP_PARITY_EN
        push_req = rx_valid && !rx_stop_err && !rx_parity_err;
        wr_tag   = 1'b0;
`else
        push_req = rx_valid && !rx_stop_err;
        wr_tag   = rx_parity_err;
`endif
        // A full FIFO still accepts a push when the head leaves in the same
        // cycle, since the freed slot is the one being written.
        push_ok   = push_req && (!full || pop);
        push_drop = push_req && full && !pop;
    end

    // FIFO write, pointer and occupancy update
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = {wr_tag, rx_data};
            wr_ptr_d        = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        if (push_ok && !pop) begin
            count_d = count_q + ONE_OCC;
        end else if (pop && !push_ok) begin
            count_d = count_q - ONE_OCC;
        end
    end

    // Statistics: sticky overrun and saturating error counters, clr_stats wins
    always_comb begin
        overrun_d  = overrun_q;
        par_cnt_d  = par_cnt_q;
        stop_cnt_d = stop_cnt_q;

        if (push_drop) begin
            overrun_d = 1'b1;
        end
        if (rx_parity_err && (par_cnt_q != CNT_MAX)) begin
            par_cnt_d = par_cnt_q + ONE_CNT;
        end
        if (rx_stop_err && (stop_cnt_q != CNT_MAX)) begin
            stop_cnt_d = stop_cnt_q + ONE_CNT;
        end
        if (clr_stats) begin
            overrun_d  = 1'b0;
            par_cnt_d  = '0;
            stop_cnt_d = '0;
        end
    end

    // Control and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            par_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            par_cnt_q  <= par_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Entry storage; contents need no reset because outputs are gated by m_valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Head entry presented directly from storage (fall-through)
    always_comb begin
        head    = mem_q[rd_ptr_q];
        m_valid = (count_q != '0);
        m_data  = m_valid ? head[WIDTH-1:0] : '0;
`ifdef RX_CTRL_DROP_PARITY_EN
        m_err   = 1'b0;
`else
        m_err   = m_valid ? head[WIDTH] : 1'b0;
`endif
        fifo_count     = count_q;
        overrun        = overrun_q;
        parity_err_cnt = par_cnt_q;
        stop_err_cnt   = stop_cnt_q;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (WIDTH=8, DEPTH=8, CNT_W=8).
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_parity_err;
   logic       rx_stop_err;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_err;
   logic       m_ready;
   logic [3:0] fifo_count;
   logic       overrun;
   logic [7:0] parity_err_cnt;
   logic [7:0] stop_err_cnt;
   logic       clr_stats;

   int n_cmp = 0;
   int n_err = 0;

   uart_rx_ctrl #(.WIDTH(8), .DEPTH(8), .CNT_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .rx_parity_err  (rx_parity_err),
      .rx_stop_err    (rx_stop_err),
      .m_valid        (m_valid),
      .m_data         (m_data),
      .m_err          (m_err),
      .m_ready        (m_ready),
      .fifo_count     (fifo_count),
      .overrun        (overrun),
      .parity_err_cnt (parity_err_cnt),
      .stop_err_cnt   (stop_err_cnt),
      .clr_stats      (clr_stats)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      rx_valid = 1'b1;
      rx_data  = d;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_parity_err = 1'b0;
      rx_stop_err = 1'b0; m_ready = 1'b0; clr_stats = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_m_valid", m_valid, 1'b0);
      check("rst_count", fifo_count, 4'd0);
      check("rst_m_data", m_data, 8'h00);
      check("rst_m_err", m_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_par_cnt", parity_err_cnt, 8'd0);
      check("rst_stop_cnt", stop_err_cnt, 8'd0);

      push(8'hA5);
      check("lat_m_valid", m_valid, 1'b1);
      check("lat_m_data", m_data, 8'hA5);
      push(8'h3C);
      check("two_count", fifo_count, 4'd2);
      check("two_m_data", m_data, 8'hA5);
      check("two_m_err", m_err, 1'b0);
      tick();
      check("stall_m_data", m_data, 8'hA5);
      m_ready = 1'b1;
      tick();
      check("pop1_m_data", m_data, 8'h3C);
      check("pop1_count", fifo_count, 4'd1);
      tick();
      check("pop2_m_valid", m_valid, 1'b0);
      check("pop2_count", fifo_count, 4'd0);
      m_ready = 1'b0;

      for (int i = 0; i < 8; i++) push(8'(i));
      check("full_count", fifo_count, 4'd8);
      check("full_overrun_pre", overrun, 1'b0);
      push(8'hFF);
      check("ovr_overrun", overrun, 1'b1);
      check("ovr_count", fifo_count, 4'd8);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_data", m_data, 8'(i));
         tick();
      end
      m_ready = 1'b0;
      check("drain_empty", m_valid, 1'b0);
      check("drain_overrun_sticky", overrun, 1'b1);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("clr_overrun", overrun, 1'b0);

      for (int i = 0; i < 8; i++) push(8'(i));
      rx_valid = 1'b1; rx_data = 8'h55; m_ready = 1'b1;
      tick();
      rx_valid = 1'b0;
      check("pp_overrun", overrun, 1'b0);
      check("pp_count", fifo_count, 4'd8);
      for (int i = 1; i < 8; i++) begin
         check("pp_drain_data", m_data, 8'(i));
         tick();
      end
      check("pp_last_data", m_data, 8'h55);
      tick();
      check("pp_empty", m_valid, 1'b0);
      m_ready = 1'b0;

      rx_valid = 1'b1; rx_data = 8'h81; rx_parity_err = 1'b1;
      tick();
      rx_valid = 1'b0; rx_parity_err = 1'b0;
      check("par_cnt", parity_err_cnt, 8'd1);
      check("par_overrun", overrun, 1'b0);
`ifdef RX_CTRL_DROP_PARITY_EN
      check("par_drop_valid", m_valid, 1'b0);
      check("par_drop_count", fifo_count, 4'd0);
`else
      check("par_tag_data", m_data, 8'h81);
      check("par_tag_err", m_err, 1'b1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check("par_tag_empty", m_valid, 1'b0);
`endif

      for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
      check("sat_pre_overrun", overrun, 1'b1);
      rx_stop_err = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      check("stop_sat", stop_err_cnt, 8'd255);
      tick();
      check("stop_hold", stop_err_cnt, 8'd255);
      check("stop_no_push", fifo_count, 4'd8);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0; rx_stop_err = 1'b0;
      check("clr_stop_cnt", stop_err_cnt, 8'd0);
      check("clr_overrun2", overrun, 1'b0);
      check("clr_par_cnt", parity_err_cnt, 8'd0);
      check("clr_keeps_fifo", fifo_count, 4'd8);
      check("clr_keeps_head", m_data, 8'h20);

      m_ready = 1'b1;
      tick(); tick(); tick();
      m_ready = 1'b0;
      check("five_count", fifo_count, 4'd5);
      rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
      tick();
      rst = 1'b0; rx_valid = 1'b0;
      check("mrst_count", fifo_count, 4'd0);
      check("mrst_m_valid", m_valid, 1'b0);
      check("mrst_m_data", m_data, 8'h00);
      check("mrst_m_err", m_err, 1'b0);
      check("mrst_overrun", overrun, 1'b0);
      push(8'h12);
      check("post_rst_data", m_data, 8'h12);
      check("post_rst_count", fifo_count, 4'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
